// File: rtl/cw_pkg.sv
// Shared sizing, types and FSM encoding for the codeword loader.
// CW_LOADER_CHKSUM_EN adds the per-beat word-sum helper used by the load checksum.
package cw_pkg;
  localparam int ANTS    = 32;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 64;
  localparam int CHUNK_W = 64;
  localparam int CW_W    = ANTS * WIDTH;
  localparam int BEATS   = CW_W / CHUNK_W;
  localparam int TOTAL   = 2 * DEPTH * BEATS;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int BEAT_W  = $clog2(BEATS);
  // one extra bit so the checksum beat index (TOTAL) is representable
  localparam int CNT_W   = $clog2(TOTAL) + 1;

  typedef logic [CW_W-1:0] codeword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

`ifdef CW_LOADER_CHKSUM_EN
  function automatic logic [31:0] chunk_sum(input logic [CHUNK_W-1:0] chunk);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < CHUNK_W / 32; i++) s = s + chunk[i*32 +: 32];
    return s;
  endfunction
`endif
endpackage

// File: rtl/cw_bank_ram.sv
// One codebook RAM (single parity of a single bank): one write port and one
// read port with a two-stage registered read path.
module cw_bank_ram
  import cw_pkg::*;
(
  input  logic              i_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CW_W-1:0]   wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CW_W-1:0]   rdata
);
  codeword_t mem [DEPTH];
  codeword_t rd_q;

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
    rdata <= rd_q;
  end
endmodule

// File: rtl/codeword_loader.sv
// Codebook writer: assembles chunked codewords into the shadow bank and serves
// reads from the active bank. CW_LOADER_CHKSUM_EN appends a checksum beat per load.
//   state | meaning
//   IDLE  | waiting for i_load_start
//   LOAD  | accepting stream beats into the shadow bank
//   DONE  | one-cycle completion pulse, swap becomes pending
//   ERR   | load failed, shadow bank is garbage until the next load
module codeword_loader
  import cw_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_start,
  input  logic [CHUNK_W-1:0] s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  input  logic               i_swap_req,
  input  logic               i_rd_en,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [CW_W-1:0]    o_rd_even,
  output logic [CW_W-1:0]    o_rd_odd,
  output logic               o_rd_valid,
  output logic               o_active_bank,
  output logic               o_load_done,
  output logic               o_load_err,
  output logic               o_swap_pending
);
  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  total_cnt;
  logic [ADDR_W-1:0] entry_addr;
  logic              half;
  codeword_t         entry_buf, wr_data;
  logic              active_bank, swap_pending;
  logic              load_go, beat_fire, entry_wrap, end_beat, good_end, swap_fire;
  logic              rd_v1, rd_v2, rd_b1, rd_b2;
  codeword_t         rdata [2][2];

  assign load_go    = i_load_start && (state_q == IDLE || state_q == ERR);
  assign beat_fire  = s_tvalid && (state_q == LOAD);
  assign entry_wrap = beat_fire && (beat_cnt == BEAT_W'(BEATS - 1))
                      && (total_cnt < CNT_W'(TOTAL));

`ifdef CW_LOADER_CHKSUM_EN
  logic [31:0] chk_sum;
  assign end_beat = (total_cnt == CNT_W'(TOTAL));
  assign good_end = s_tlast && (s_tdata[31:0] == chk_sum);

  always_ff @(posedge i_clk) begin
    if (i_reset || load_go) chk_sum <= '0;
    else if (beat_fire && (total_cnt < CNT_W'(TOTAL))) chk_sum <= chk_sum + chunk_sum(s_tdata);
  end
`else
  assign end_beat = (total_cnt == CNT_W'(TOTAL - 1));
  assign good_end = s_tlast;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    s_tready    = 1'b0;
    o_load_done = 1'b0;
    o_load_err  = 1'b0;
    case (state_q)
      IDLE: if (i_load_start) state_d = LOAD;
      LOAD: begin
        s_tready = 1'b1;
        if (beat_fire) begin
          if (end_beat)     state_d = good_end ? DONE : ERR;
          else if (s_tlast) state_d = ERR;
        end
      end
      DONE: begin
        o_load_done = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        o_load_err = 1'b1;
        if (i_load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || load_go) begin
      beat_cnt   <= '0;
      total_cnt  <= '0;
      entry_addr <= '0;
      half       <= 1'b0;
    end else if (beat_fire) begin
      total_cnt <= total_cnt + 1'b1;
      beat_cnt  <= beat_cnt + 1'b1;
      if (beat_cnt == BEAT_W'(BEATS - 1)) begin
        beat_cnt <= '0;
        half     <= ~half;
        if (half) entry_addr <= entry_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (beat_fire) entry_buf[beat_cnt*CHUNK_W +: CHUNK_W] <= s_tdata;
  end

  // the final chunk bypasses the assembler so the entry lands on the wrap cycle
  always_comb begin
    wr_data = entry_buf;
    wr_data[CW_W-CHUNK_W +: CHUNK_W] = s_tdata;
  end

  // a new load takes precedence over a same-cycle swap so the target stays the shadow bank
  assign swap_fire = i_swap_req && swap_pending && (state_q != LOAD) && !load_go;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
    end else if (load_go) begin
      swap_pending <= 1'b0;
    end else if (state_q == LOAD && state_d == DONE) begin
      swap_pending <= 1'b1;
    end else if (swap_fire) begin
      active_bank  <= ~active_bank;
      swap_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      rd_b1 <= 1'b0;
      rd_b2 <= 1'b0;
    end else begin
      rd_v1 <= i_rd_en;
      rd_v2 <= rd_v1;
      rd_b1 <= active_bank;
      rd_b2 <= rd_b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar p = 0; p < 2; p++) begin : g_par
      localparam logic BANK = 1'(b);
      localparam logic PAR  = 1'(p);
      cw_bank_ram u_ram (
        .i_clk (i_clk),
        .we    (entry_wrap && (~active_bank == BANK) && (half == PAR)),
        .waddr (entry_addr),
        .wdata (wr_data),
        .re    (i_rd_en),
        .raddr (i_rd_addr),
        .rdata (rdata[b][p])
      );
    end
  end

  assign o_rd_even      = rd_v2 ? rdata[rd_b2][0] : '0;
  assign o_rd_odd       = rd_v2 ? rdata[rd_b2][1] : '0;
  assign o_rd_valid     = rd_v2;
  assign o_active_bank  = active_bank;
  assign o_swap_pending = swap_pending;
endmodule

// File: tb/tb_codeword_loader.sv
// Directed sequence with randomized beat data and valid gaps, checked against a
// bank/entry-level model of the double-buffered codebook.
module tb_codeword_loader;
  localparam int DEPTH   = 64;
  localparam int BEATS   = 16;
  localparam int CHUNK_W = 64;
  localparam int CW_W    = 1024;
  localparam int TOTAL   = 2 * DEPTH * BEATS;
`ifdef CW_LOADER_CHKSUM_EN
  localparam int NBEATS = TOTAL + 1;
`else
  localparam int NBEATS = TOTAL;
`endif

  logic i_clk = 1'b0, i_reset = 1'b1, i_load_start = 1'b0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, i_swap_req = 1'b0, i_rd_en = 1'b0;
  logic [CHUNK_W-1:0] s_tdata = '0;
  logic [5:0] i_rd_addr = '0;
  logic s_tready, o_rd_valid, o_active_bank, o_load_done, o_load_err, o_swap_pending;
  logic [CW_W-1:0] o_rd_even, o_rd_odd;

  int tests = 0, fails = 0, done_cnt = 0;
  logic [CHUNK_W-1:0] ld_beats [NBEATS];
  logic [CW_W-1:0] m_bank [2][2][DEPTH];
  logic m_active = 1'b0, m_pending = 1'b0;

  codeword_loader dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_load_start   (i_load_start),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .i_swap_req     (i_swap_req),
    .i_rd_en        (i_rd_en),
    .i_rd_addr      (i_rd_addr),
    .o_rd_even      (o_rd_even),
    .o_rd_odd       (o_rd_odd),
    .o_rd_valid     (o_rd_valid),
    .o_active_bank  (o_active_bank),
    .o_load_done    (o_load_done),
    .o_load_err     (o_load_err),
    .o_swap_pending (o_swap_pending)
  );

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_load_done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cw(input string tag, input logic [CW_W-1:0] obs, input logic [CW_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed[127:0] %h, expected[127:0] %h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic fill(input bit plan);
    for (int k = 0; k < TOTAL; k++) begin
      int e;
      e = k / (2 * BEATS);
      if (plan) ld_beats[k] = (((k / BEATS) % 2) == 1) ? ~64'(e) : 64'(e);
      else      ld_beats[k] = {$urandom, $urandom};
    end
`ifdef CW_LOADER_CHKSUM_EN
    begin
      logic [31:0] sum;
      sum = '0;
      for (int k = 0; k < TOTAL; k++) sum = sum + ld_beats[k][31:0] + ld_beats[k][63:32];
      ld_beats[TOTAL] = {$urandom, sum};
    end
`endif
  endtask

  task automatic run_load(input int tlast_at, input bit bad_chk, input int abort_at, input string tag);
    int k, cyc, d0;
    bit acc, exp_ok, aborted;
    k = 0; cyc = 0; d0 = done_cnt; aborted = 0;
    exp_ok = (tlast_at == NBEATS - 1) && !bad_chk && (abort_at < 0);
    i_load_start = 1'b1;
    @(posedge i_clk); #1;
    i_load_start = 1'b0;
    m_pending = 1'b0;
    check({tag, " ready"}, 64'(s_tready), 64'd1);
    check({tag, " err_clr"}, 64'(o_load_err), 64'd0);
    check({tag, " pend_clr"}, 64'(o_swap_pending), 64'd0);
    while (k < NBEATS && !o_load_err && cyc < 10000) begin
      if (k == abort_at) begin
        s_tvalid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        aborted = 1;
        break;
      end
      s_tvalid = ($urandom_range(0, 6) != 0);
      s_tdata  = ld_beats[k];
      if (bad_chk && k == TOTAL) s_tdata[0] = ~s_tdata[0];
      s_tlast  = (k == tlast_at);
      acc = s_tvalid && s_tready;
      @(posedge i_clk); #1;
      if (acc) k++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check({tag, " no_timeout"}, 64'(cyc < 10000), 64'd1);
    if (aborted) begin
      m_active = 1'b0;
      m_pending = 1'b0;
      check({tag, " rst_ready"}, 64'(s_tready), 64'd0);
      check({tag, " rst_active"}, 64'(o_active_bank), 64'd0);
      check({tag, " rst_pend"}, 64'(o_swap_pending), 64'd0);
      check({tag, " rst_err"}, 64'(o_load_err), 64'd0);
      return;
    end
    @(posedge i_clk); #1;
    if (exp_ok) begin
      for (int n = 0; n < 2 * DEPTH; n++) begin
        logic [CW_W-1:0] ent;
        for (int c = 0; c < BEATS; c++) ent[c*CHUNK_W +: CHUNK_W] = ld_beats[n*BEATS + c];
        m_bank[~m_active][n % 2][n / 2] = ent;
      end
      m_pending = 1'b1;
    end
    check({tag, " done_pulses"}, 64'(done_cnt - d0), exp_ok ? 64'd1 : 64'd0);
    check({tag, " err"}, 64'(o_load_err), exp_ok ? 64'd0 : 64'd1);
    check({tag, " pending"}, 64'(o_swap_pending), 64'(m_pending));
    check({tag, " active"}, 64'(o_active_bank), 64'(m_active));
    check({tag, " ready_after"}, 64'(s_tready), 64'd0);
  endtask

  task automatic do_swap(input string tag);
    i_swap_req = 1'b1;
    @(posedge i_clk); #1;
    i_swap_req = 1'b0;
    if (m_pending) begin
      m_active = ~m_active;
      m_pending = 1'b0;
    end
    check({tag, " active"}, 64'(o_active_bank), 64'(m_active));
    check({tag, " pending"}, 64'(o_swap_pending), 64'(m_pending));
  endtask

  task automatic read_burst(input int n, input string tag);
    logic [5:0] addrs [$];
    logic       bks [$];
    for (int j = 0; j <= n + 1; j++) begin
      if (j < n) begin
        i_rd_en   = 1'b1;
        i_rd_addr = 6'($urandom_range(0, DEPTH - 1));
        addrs.push_back(i_rd_addr);
        bks.push_back(m_active);
      end else begin
        i_rd_en = 1'b0;
      end
      @(posedge i_clk); #1;
      if (j >= 1 && j <= n) begin
        logic [5:0] a;
        logic       b;
        a = addrs.pop_front();
        b = bks.pop_front();
        check({tag, " valid"}, 64'(o_rd_valid), 64'd1);
        check_cw({tag, " even"}, o_rd_even, m_bank[b][0][a]);
        check_cw({tag, " odd"}, o_rd_odd, m_bank[b][1][a]);
      end else if (j == n + 1) begin
        check({tag, " valid_drop"}, 64'(o_rd_valid), 64'd0);
      end
    end
  endtask

  initial begin
    logic [CW_W-1:0] pe, po, exp_e, exp_o;
    logic [CHUNK_W-1:0] c5;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst ready", 64'(s_tready), 64'd0);
    check("rst active", 64'(o_active_bank), 64'd0);
    check("rst done", 64'(o_load_done), 64'd0);
    check("rst err", 64'(o_load_err), 64'd0);
    check("rst pending", 64'(o_swap_pending), 64'd0);
    check("rst rd_valid", 64'(o_rd_valid), 64'd0);
    check_cw("rst rd_even", o_rd_even, '0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // test-plan pattern into bank 1, then swap and read entry 5
    fill(1'b1);
    run_load(NBEATS - 1, 1'b0, -1, "load_a");
    do_swap("swap_a");
    c5 = 64'd5;
    pe = {16{c5}};
    po = {16{~c5}};
    i_rd_en = 1'b1;
    i_rd_addr = 6'd5;
    @(posedge i_clk); #1;
    i_rd_en = 1'b0;
    @(posedge i_clk); #1;
    check("rd5 valid", 64'(o_rd_valid), 64'd1);
    check_cw("rd5 even", o_rd_even, pe);
    check_cw("rd5 odd", o_rd_odd, po);
    read_burst(20, "burst_a");

    // early tlast aborts; a following swap request must do nothing
    fill(1'b0);
    run_load(100, 1'b0, -1, "early_tlast");
    do_swap("swap_none");
    read_burst(8, "burst_after_err");

    // swap landing one cycle after a read does not affect that read
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, -1, "load_b");
    exp_e = m_bank[m_active][0][3];
    exp_o = m_bank[m_active][1][3];
    i_rd_en = 1'b1;
    i_rd_addr = 6'd3;
    @(posedge i_clk); #1;
    i_rd_en = 1'b0;
    i_swap_req = 1'b1;
    @(posedge i_clk); #1;
    i_swap_req = 1'b0;
    m_active = ~m_active;
    m_pending = 1'b0;
    check("rd3 valid", 64'(o_rd_valid), 64'd1);
    check_cw("rd3 even old", o_rd_even, exp_e);
    check_cw("rd3 odd old", o_rd_odd, exp_o);
    check("rd3 swapped", 64'(o_active_bank), 64'(m_active));
    read_burst(8, "burst_b");

    // get active=1, then reset in the middle of the next load
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, -1, "load_d");
    do_swap("swap_d");
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, 1000, "reset_mid");

    // full load, then restart it while the swap is pending
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, -1, "load_e");
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, -1, "load_f_restart");
    do_swap("swap_f");
    read_burst(12, "burst_f");

    // missing tlast on the final beat
    fill(1'b0);
    run_load(-1, 1'b0, -1, "no_tlast");
    do_swap("swap_none2");

`ifdef CW_LOADER_CHKSUM_EN
    fill(1'b0);
    run_load(NBEATS - 1, 1'b1, -1, "bad_chk");
    fill(1'b0);
    run_load(NBEATS - 1, 1'b0, -1, "good_chk");
    do_swap("swap_chk");
    read_burst(8, "burst_chk");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
